// File: rtl/drr_pkg.sv
// Shared types and width helpers for the deficit-round-robin FIFO scheduler.
package drr_pkg;

   typedef enum logic {
      SCAN  = 1'b0,
      SERVE = 1'b1
   } drr_state_t;

   typedef enum logic [1:0] {
      DEF_HOLD = 2'd0,
      DEF_ADD  = 2'd1,
      DEF_SUB  = 2'd2,
      DEF_CLR  = 2'd3
   } def_op_t;

   // One extra bit lets a full quantum stack on top of an almost-full residual.
   function automatic int calc_dwid(input int qwid, input int swid);
      return ((qwid > swid) ? qwid : swid) + 1;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/drr_deficit_bank.sv
// Per-requester deficit counters with a single indexed add/sub/clear port.
module drr_deficit_bank
   import drr_pkg::*;
#(
   parameter int NUM_REQS = 4,
   parameter int DWID     = 9,
   parameter int IDXW     = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IDXW-1:0] idx,
   input  def_op_t         op,
   input  logic [DWID-1:0] operand,
   output logic [DWID-1:0] cur_deficit
);

   logic [DWID-1:0] deficit_q [NUM_REQS];
   logic [DWID:0]   add_sum;
   logic [DWID-1:0] upd_value;

   assign cur_deficit = deficit_q[idx];

   // Additions saturate; the caller only subtracts what the counter already holds.
   always_comb begin
      add_sum   = {1'b0, cur_deficit} + {1'b0, operand};
      upd_value = cur_deficit;
      case (op)
         DEF_ADD: upd_value = add_sum[DWID] ? '1 : add_sum[DWID-1:0];
         DEF_SUB: upd_value = cur_deficit - operand;
         DEF_CLR: upd_value = '0;
         default: upd_value = cur_deficit;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REQS; i++) begin
            deficit_q[i] <= '0;
         end
      end else if (op != DEF_HOLD) begin
         deficit_q[idx] <= upd_value;
      end
   end

endmodule

// File: rtl/drr_fifo_sched.sv
// Deficit-round-robin scheduler choosing which per-requester FIFO pops onto the
// shared output, charging each requester by packet size against its quantum.
module drr_fifo_sched
   import drr_pkg::*;
#(
   parameter int NUM_REQS = 4,
   parameter int QWID     = 8,
   parameter int SWID     = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQS-1:0]             reqs,
   input  logic [NUM_REQS*SWID-1:0]        sizes,
   input  logic [NUM_REQS*QWID-1:0]        quantums,
   input  logic                            blk,
   input  logic                            out_ready,
   output logic [NUM_REQS-1:0]             gnt,
   output logic                            gnt_valid,
   output logic [idx_width(NUM_REQS)-1:0]  gnt_idx
);

   localparam int DWID = calc_dwid(QWID, SWID);
   localparam int IDXW = idx_width(NUM_REQS);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REQS - 1);

   drr_state_t      state, state_next;
   logic [IDXW-1:0] ptr, ptr_next, ptr_adv;
   logic [SWID-1:0] size_arr  [NUM_REQS];
   logic [QWID-1:0] quant_arr [NUM_REQS];
   logic [DWID-1:0] size_eff;
   logic [DWID-1:0] quant_ext;
   logic [DWID-1:0] cur_deficit;
   logic [DWID-1:0] bank_operand;
   def_op_t         bank_op;
   logic            cur_req;
   logic            fits;

   for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
      assign size_arr[g]  = sizes[g*SWID +: SWID];
      assign quant_arr[g] = quantums[g*QWID +: QWID];
   end

   // A zero-length head still costs one unit so a requester can never loop for free.
   assign cur_req   = reqs[ptr];
   assign size_eff  = (size_arr[ptr] == '0) ? DWID'(1) : DWID'(size_arr[ptr]);
   assign quant_ext = DWID'(quant_arr[ptr]);
   assign fits      = (size_eff <= cur_deficit);
   assign ptr_adv   = (ptr == LAST_IDX) ? '0 : ptr + IDXW'(1);

   assign gnt_valid = (state == SERVE) && cur_req && fits && !blk;
   assign gnt       = gnt_valid ? (NUM_REQS'(1) << ptr) : '0;
   assign gnt_idx   = ptr;

   drr_deficit_bank #(
      .NUM_REQS (NUM_REQS),
      .DWID     (DWID),
      .IDXW     (IDXW)
   ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .idx         (ptr),
      .op          (bank_op),
      .operand     (bank_operand),
      .cur_deficit (cur_deficit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= SCAN;
         ptr   <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
      end
   end

   // SCAN tops up the visited requester; SERVE drains it until the head no longer fits.
   always_comb begin
      state_next   = state;
      ptr_next     = ptr;
      bank_op      = DEF_HOLD;
      bank_operand = '0;
      if (!blk) begin
         case (state)
            SCAN: begin
               if (cur_req) begin
                  bank_op      = DEF_ADD;
                  bank_operand = quant_ext;
                  state_next   = SERVE;
               end else begin
                  bank_op  = DEF_CLR;
                  ptr_next = ptr_adv;
               end
            end
            SERVE: begin
               if (!cur_req) begin
                  bank_op    = DEF_CLR;
                  ptr_next   = ptr_adv;
                  state_next = SCAN;
               end else if (!fits) begin
                  ptr_next   = ptr_adv;
                  state_next = SCAN;
               end else if (out_ready) begin
                  bank_op      = DEF_SUB;
                  bank_operand = size_eff;
               end
            end
            default: state_next = SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_drr_fifo_sched.sv
// Self-checking bench for drr_fifo_sched: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a behavioural DRR model.
module tb_drr_fifo_sched;

   localparam int NUM_REQS = 4;
   localparam int QWID     = 8;
   localparam int SWID     = 8;
   localparam int DMAX     = 511;

   logic        clk;
   logic        rst;
   logic [3:0]  reqs;
   logic [31:0] sizes;
   logic [31:0] quantums;
   logic        blk;
   logic        out_ready;
   logic [3:0]  gnt;
   logic        gnt_valid;
   logic [1:0]  gnt_idx;

   int tests_run;
   int tests_failed;

   int m_def [NUM_REQS];
   int m_ptr;
   bit m_serving;

   logic [3:0] last_gnt;
   logic       last_valid;
   bit         last_hold;

   logic [3:0]  hold_reqs;
   logic [31:0] hold_sizes;
   bit          hold_prev;

   drr_fifo_sched #(
      .NUM_REQS (NUM_REQS),
      .QWID     (QWID),
      .SWID     (SWID)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .reqs      (reqs),
      .sizes     (sizes),
      .quantums  (quantums),
      .blk       (blk),
      .out_ready (out_ready),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Requesters must keep reqs/sizes stable while a grant is stalled by backpressure.
   always @(negedge clk) begin
      if (rst && hold_prev) begin
         assert (reqs == hold_reqs && sizes == hold_sizes)
            else $error("[TB] requester protocol violated at %0t", $time);
      end
      hold_prev  = rst && gnt_valid && !out_ready;
      hold_reqs  = reqs;
      hold_sizes = sizes;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, tests so far %0d", tests_run);
      $fatal(1);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int eff_size(input int i);
      logic [7:0] s;
      s = sizes[i*SWID +: SWID];
      return (s == 8'd0) ? 1 : int'(s);
   endfunction

   function automatic int quantum_of(input int i);
      logic [7:0] q;
      q = quantums[i*QWID +: QWID];
      return int'(q);
   endfunction

   function automatic bit model_valid();
      return m_serving && reqs[m_ptr] && (eff_size(m_ptr) <= m_def[m_ptr]) && !blk;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NUM_REQS; i++) m_def[i] = 0;
      m_ptr     = 0;
      m_serving = 0;
   endfunction

   function automatic void model_step();
      int p;
      int se;
      p  = m_ptr;
      se = eff_size(p);
      if (blk) return;
      if (!m_serving) begin
         if (reqs[p]) begin
            m_def[p]  = (m_def[p] + quantum_of(p) > DMAX) ? DMAX : m_def[p] + quantum_of(p);
            m_serving = 1;
         end else begin
            m_def[p] = 0;
            m_ptr    = (p + 1) % NUM_REQS;
         end
      end else if (!reqs[p]) begin
         m_def[p]  = 0;
         m_ptr     = (p + 1) % NUM_REQS;
         m_serving = 0;
      end else if (se > m_def[p]) begin
         m_ptr     = (p + 1) % NUM_REQS;
         m_serving = 0;
      end else if (out_ready) begin
         m_def[p] = m_def[p] - se;
      end
   endfunction

   // One clock cycle: drive, compare Mealy outputs mid-cycle, then advance model and clock.
   task automatic applyStimulus(input logic [3:0] r, input logic [31:0] s, input logic [31:0] q,
                                input logic b, input logic o);
      bit         ev;
      logic [3:0] eg;
      reqs = r; sizes = s; quantums = q; blk = b; out_ready = o;
      #3;
      ev = model_valid();
      eg = ev ? (4'b0001 << m_ptr) : 4'b0000;
      checkOutput("gnt_valid", 32'(gnt_valid), 32'(ev));
      checkOutput("gnt", 32'(gnt), 32'(eg));
      if (ev) checkOutput("gnt_idx", 32'(gnt_idx), 32'(m_ptr));
      last_gnt   = gnt;
      last_valid = gnt_valid;
      last_hold  = ev && !o;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic runUntilGrant(input logic [3:0] r, input logic [31:0] s, input logic [31:0] q,
                                input logic o, input int max_cycles, output int cyc);
      cyc = 0;
      for (int i = 1; i <= max_cycles; i++) begin
         applyStimulus(r, s, q, 1'b0, o);
         if (last_valid) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic doReset();
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      last_hold = 0;
   endtask

   initial begin
      logic [11:0] pattern;
      logic [3:0]  r;
      logic [31:0] s;
      logic [31:0] q;
      int cyc;
      int cnt0;
      int cnt1;
      int total;

      tests_run = 0; tests_failed = 0;
      hold_prev = 0; last_hold = 0;
      rst = 1'b0; reqs = '0; sizes = '0; quantums = '0; blk = 1'b0; out_ready = 1'b0;
      model_reset();
      #3;
      checkOutput("reset_gnt", 32'(gnt), 32'h0);
      checkOutput("reset_valid", 32'(gnt_valid), 32'h0);
      checkOutput("reset_idx", 32'(gnt_idx), 32'h0);
      doReset();

      // Single requester: quantum 10, size 4
      for (int c = 0; c < 12; c++) begin
         applyStimulus(4'b0001, 32'h00000004, 32'h0000000A, 1'b0, 1'b1);
         pattern[c] = last_valid;
      end
      checkOutput("single_pattern", 32'(pattern), 32'h706);

      // Asynchronous reset while a grant is live
      doReset();
      applyStimulus(4'b1111, 32'h04040404, 32'h0A0A0A0A, 1'b0, 1'b1);
      #2;
      checkOutput("pre_rst_gnt", 32'(gnt), 32'h1);
      rst = 1'b0;
      #1;
      checkOutput("rst_async_gnt", 32'(gnt), 32'h0);
      checkOutput("rst_async_valid", 32'(gnt_valid), 32'h0);
      checkOutput("rst_async_idx", 32'(gnt_idx), 32'h0);
      doReset();
      applyStimulus(4'b1111, 32'h04040404, 32'h0A0A0A0A, 1'b0, 1'b1);
      applyStimulus(4'b1111, 32'h04040404, 32'h0A0A0A0A, 1'b0, 1'b1);
      checkOutput("first_gnt_after_rst", 32'(last_gnt), 32'h1);

      // Weighting 2:1 by quantum
      doReset();
      cnt0 = 0; cnt1 = 0; total = 0;
      for (int i = 0; i < 3000 && total < 300; i++) begin
         applyStimulus(4'b0011, 32'h05050505, 32'h0000050A, 1'b0, 1'b1);
         if (last_gnt[0]) cnt0++;
         if (last_gnt[1]) cnt1++;
         if (last_valid) total++;
      end
      checkOutput("wt_total", 32'(total), 32'd300);
      checkOutput("wt_req0_near_200", 32'(cnt0 >= 198 && cnt0 <= 202), 32'h1);
      checkOutput("wt_req1_near_100", 32'(cnt1 >= 98 && cnt1 <= 102), 32'h1);

      // Backpressure on requester 1
      doReset();
      runUntilGrant(4'b0010, 32'h00000300, 32'h00000900, 1'b0, 8, cyc);
      checkOutput("bp_first_grant_cycle", 32'(cyc), 32'd3);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b0010, 32'h00000300, 32'h00000900, 1'b0, 1'b0);
         checkOutput("bp_gnt_held", 32'(last_gnt), 32'h2);
      end
      cnt0 = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(4'b0010, 32'h00000300, 32'h00000900, 1'b0, 1'b1);
         if (last_valid) cnt0++;
         else break;
      end
      checkOutput("bp_grants_after_ready", 32'(cnt0), 32'd3);

      // Residual deficit cleared when requester 2 is visited idle
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(4'b0100, 32'h00080000, 32'h000F0000, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(4'b0000, 32'h00080000, 32'h000F0000, 1'b0, 1'b1);
      runUntilGrant(4'b0100, 32'h00080000, 32'h00050000, 1'b1, 20, cyc);
      checkOutput("clear_first_grant_cycle", 32'(cyc), 32'd9);

      // Oversize packet: size 200, quantum 50 -> fourth visit
      doReset();
      runUntilGrant(4'b1000, 32'hC8000000, 32'h32000000, 1'b1, 40, cyc);
      checkOutput("oversize_first_grant_cycle", 32'(cyc), 32'd20);

      // Freeze during SERVE
      doReset();
      applyStimulus(4'b0001, 32'h00000004, 32'h0000000A, 1'b0, 1'b1);
      applyStimulus(4'b0001, 32'h00000004, 32'h0000000A, 1'b0, 1'b1);
      checkOutput("frz_pre_grant", 32'(last_valid), 32'h1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b0001, 32'h00000004, 32'h0000000A, 1'b1, 1'b1);
         checkOutput("frz_gnt_zero", 32'(last_gnt), 32'h0);
      end
      applyStimulus(4'b0001, 32'h00000004, 32'h0000000A, 1'b0, 1'b1);
      checkOutput("frz_resume_gnt", 32'(last_gnt), 32'h1);
      applyStimulus(4'b0001, 32'h00000004, 32'h0000000A, 1'b0, 1'b1);
      checkOutput("frz_after_drain", 32'(last_valid), 32'h0);

      // Size 0 counts as 1: quantum 3 gives three grants per visit
      doReset();
      cnt0 = 0;
      for (int i = 0; i < 13; i++) begin
         applyStimulus(4'b0001, 32'h00000000, 32'h00000003, 1'b0, 1'b1);
         if (last_valid) cnt0++;
      end
      checkOutput("size0_grants_two_visits", 32'(cnt0), 32'd6);

      // Randomized traffic, honouring the hold rule under backpressure
      r = reqs; s = sizes; q = quantums;
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) doReset();
         if (!last_hold) begin
            r = 4'($urandom);
            for (int i = 0; i < NUM_REQS; i++) s[i*SWID +: SWID] = 8'($urandom_range(0, 20));
         end
         if (c % 200 == 0) begin
            for (int i = 0; i < NUM_REQS; i++) q[i*QWID +: QWID] = 8'($urandom_range(0, 24));
         end
         applyStimulus(r, s, q, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
